// File: rtl/fifo_umbral.sv
// fifo_umbral: 8-deep synchronous FIFO with registered read data,
// programmable almost-empty/almost-full thresholds and sticky error.
module fifo_umbral #(
  parameter int DATA_WIDTH = 6,
  parameter int ADDR_WIDTH = 3
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  wr_enable,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic                  rd_enable,
  input  logic [2:0]            umbral_L,
  input  logic [2:0]            umbral_H,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  valid_out,
  output logic                  fifo_empty,
  output logic                  fifo_full,
  output logic                  almost_empty,
  output logic                  almost_full,
  output logic                  error_out
);

  localparam int DEPTH = 1 << ADDR_WIDTH;
  localparam int CW    = ADDR_WIDTH + 1;

  localparam logic [CW-1:0]         CNT_FULL = CW'(DEPTH);
  localparam logic [CW-1:0]         CNT_ONE  = CW'(1);
  localparam logic [ADDR_WIDTH-1:0] PTR_ONE  = ADDR_WIDTH'(1);

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [ADDR_WIDTH-1:0] wr_ptr;
  logic [ADDR_WIDTH-1:0] rd_ptr;
  logic [CW-1:0]         count;
  logic [2:0]            umbral_L_reg;
  logic [2:0]            umbral_H_reg;
  logic [CW-1:0]         af_level;
  logic                  wr_acc;
  logic                  rd_acc;
  logic                  err_set;

  // Status flags decode straight from the registered count/thresholds
  assign fifo_empty   = (count == '0);
  assign fifo_full    = (count == CNT_FULL);
  assign af_level     = CNT_FULL - CW'(umbral_H_reg);
  assign almost_empty = (count <= CW'(umbral_L_reg));
  assign almost_full  = (count >= af_level);

  // Full blocks the write, empty blocks the read (no read-through)
  assign wr_acc  = wr_enable & ~fifo_full;
  assign rd_acc  = rd_enable & ~fifo_empty;
  assign err_set = (wr_enable & fifo_full & ~rd_acc)
                 | (rd_enable & fifo_empty);

  // Threshold inputs are captured each cycle; flags lag them by one
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      umbral_L_reg <= '0;
      umbral_H_reg <= '0;
    end else begin
      umbral_L_reg <= umbral_L;
      umbral_H_reg <= umbral_H;
    end
  end

  // Storage array has no reset; entries are only read after a write
  always_ff @(posedge clk) begin
    if (wr_acc) begin
      mem[wr_ptr] <= data_in;
    end
  end

  // Pointers wrap naturally at DEPTH; count tracks occupancy
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_acc) begin
        wr_ptr <= wr_ptr + PTR_ONE;
      end
      if (rd_acc) begin
        rd_ptr <= rd_ptr + PTR_ONE;
      end
      unique case ({wr_acc, rd_acc})
        2'b10:   count <= count + CNT_ONE;
        2'b01:   count <= count - CNT_ONE;
        default: count <= count;
      endcase
    end
  end

  // Registered read port; data_out holds between reads
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      data_out  <= '0;
      valid_out <= 1'b0;
    end else begin
      valid_out <= rd_acc;
      if (rd_acc) begin
        data_out <= mem[rd_ptr];
      end
    end
  end

  // Sticky overflow/underflow flag, cleared only by reset
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      error_out <= 1'b0;
    end else if (err_set) begin
      error_out <= 1'b1;
    end
  end

endmodule

// File: tb/tb_fifo_umbral.sv
// tb_fifo_umbral: table vectors plus scoreboard-checked sequences
// for the thresholded FIFO.
module tb_fifo_umbral;

  logic       clk;
  logic       reset;
  logic       wr_enable;
  logic [5:0] data_in;
  logic       rd_enable;
  logic [2:0] umbral_L;
  logic [2:0] umbral_H;
  logic [5:0] data_out;
  logic       valid_out;
  logic       fifo_empty;
  logic       fifo_full;
  logic       almost_empty;
  logic       almost_full;
  logic       error_out;

  fifo_umbral #(.DATA_WIDTH(6), .ADDR_WIDTH(3)) dut (
    .clk(clk),
    .reset(reset),
    .wr_enable(wr_enable),
    .data_in(data_in),
    .rd_enable(rd_enable),
    .umbral_L(umbral_L),
    .umbral_H(umbral_H),
    .data_out(data_out),
    .valid_out(valid_out),
    .fifo_empty(fifo_empty),
    .fifo_full(fifo_full),
    .almost_empty(almost_empty),
    .almost_full(almost_full),
    .error_out(error_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       wr;
    logic       rd;
    logic [5:0] din;
    logic [2:0] ul;
    logic [2:0] uh;
    logic       e_empty;
    logic       e_full;
    logic       e_ae;
    logic       e_af;
    logic       e_err;
  } vec_t;

  vec_t       tbl [9];
  int         total;
  int         bad;
  int         m_count;
  int         m_ul;
  int         m_uh;
  bit         m_err;
  logic [5:0] q [$];

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    m_count = 0;
    m_ul    = 0;
    m_uh    = 0;
    m_err   = 1'b0;
    q.delete();
  endtask

  task automatic reset_checks(input string tag);
    chk({tag, "_empty"}, fifo_empty, 1);
    chk({tag, "_full"}, fifo_full, 0);
    chk({tag, "_ae"}, almost_empty, 1);
    chk({tag, "_af"}, almost_full, 0);
    chk({tag, "_err"}, error_out, 0);
    chk({tag, "_valid"}, valid_out, 0);
    chk({tag, "_dout"}, data_out, 0);
  endtask

  // Ends at a falling edge with reset released
  task automatic do_reset();
    @(negedge clk);
    wr_enable = 1'b0;
    rd_enable = 1'b0;
    reset     = 1'b1;
    #1;
    model_reset();
    reset_checks("rst");
    @(negedge clk);
    reset = 1'b0;
  endtask

  // Drive one cycle, predict with the model, compare after the edge
  task automatic cycle(input bit wr, input bit rd, input logic [5:0] din,
                       input int ul, input int uh);
    bit wa;
    bit ra;
    wr_enable = wr;
    rd_enable = rd;
    data_in   = din;
    umbral_L  = 3'(ul);
    umbral_H  = 3'(uh);
    wa = wr && (m_count != 8);
    ra = rd && (m_count != 0);
    if ((wr && m_count == 8 && !ra) || (rd && m_count == 0)) m_err = 1'b1;
    if (wa) q.push_back(din);
    @(posedge clk);
    #1;
    m_count = m_count + int'(wa) - int'(ra);
    m_ul = ul;
    m_uh = uh;
    chk("valid_out", valid_out, ra);
    if (valid_out === 1'b1) begin
      if (q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL sb_underrun: got data %0h want none", data_out);
      end else begin
        chk("data_out", data_out, q.pop_front());
      end
    end
    chk("fifo_empty", fifo_empty, m_count == 0);
    chk("fifo_full", fifo_full, m_count == 8);
    chk("almost_empty", almost_empty, m_count <= m_ul);
    chk("almost_full", almost_full, m_count >= 8 - m_uh);
    chk("error_out", error_out, m_err);
  endtask

  initial begin
    total     = 0;
    bad       = 0;
    reset     = 1'b0;
    wr_enable = 1'b0;
    rd_enable = 1'b0;
    data_in   = '0;
    umbral_L  = '0;
    umbral_H  = '0;
    model_reset();

    // Threshold sweep, L=2 H=3, count 0..8 writing 0x01..0x08
    tbl[0] = '{0, 0, 6'h00, 2, 3, 1, 0, 1, 0, 0};
    tbl[1] = '{1, 0, 6'h01, 2, 3, 0, 0, 1, 0, 0};
    tbl[2] = '{1, 0, 6'h02, 2, 3, 0, 0, 1, 0, 0};
    tbl[3] = '{1, 0, 6'h03, 2, 3, 0, 0, 0, 0, 0};
    tbl[4] = '{1, 0, 6'h04, 2, 3, 0, 0, 0, 0, 0};
    tbl[5] = '{1, 0, 6'h05, 2, 3, 0, 0, 0, 1, 0};
    tbl[6] = '{1, 0, 6'h06, 2, 3, 0, 0, 0, 1, 0};
    tbl[7] = '{1, 0, 6'h07, 2, 3, 0, 0, 0, 1, 0};
    tbl[8] = '{1, 0, 6'h08, 2, 3, 0, 1, 0, 1, 0};

    do_reset();

    for (int i = 0; i < 9; i++) begin
      cycle(tbl[i].wr, tbl[i].rd, tbl[i].din, tbl[i].ul, tbl[i].uh);
      chk($sformatf("tbl%0d_empty", i), fifo_empty, tbl[i].e_empty);
      chk($sformatf("tbl%0d_full", i), fifo_full, tbl[i].e_full);
      chk($sformatf("tbl%0d_ae", i), almost_empty, tbl[i].e_ae);
      chk($sformatf("tbl%0d_af", i), almost_full, tbl[i].e_af);
      chk($sformatf("tbl%0d_err", i), error_out, tbl[i].e_err);
    end

    // Overflow write is dropped and latches the error
    cycle(1, 0, 6'h3F, 2, 3);
    chk("ovf_err", error_out, 1);
    chk("ovf_full", fifo_full, 1);

    // Drain: 0x01..0x08 in order via the scoreboard
    for (int i = 0; i < 8; i++) cycle(0, 1, 6'h00, 2, 3);
    chk("drain_empty", fifo_empty, 1);
    chk("drain_last", data_out, 6'h08);

    // Underflow read: no valid, error stays set
    cycle(0, 1, 6'h00, 2, 3);
    chk("udf_valid", valid_out, 0);
    chk("udf_err", error_out, 1);
    chk("udf_hold", data_out, 6'h08);

    // Count 4, then simultaneous traffic across the pointer wrap
    do_reset();
    for (int i = 0; i < 4; i++) cycle(1, 0, 6'(8'h10 + i), 2, 3);
    umbral_L = 3'd4;
    #1;
    chk("thr_pre_edge_ae", almost_empty, 0);
    cycle(0, 0, 6'h00, 4, 3);
    chk("thr_post_edge_ae", almost_empty, 1);
    cycle(0, 0, 6'h00, 2, 3);
    for (int i = 0; i < 10; i++) cycle(1, 1, 6'(8'h20 + i), 2, 3);
    chk("wrap_count4", m_count, 4);
    for (int i = 0; i < 4; i++) cycle(0, 1, 6'h00, 2, 3);
    chk("wrap_last", data_out, 6'h29);
    chk("wrap_empty", fifo_empty, 1);

    // Both requests while empty, then while full
    do_reset();
    cycle(1, 1, 6'h05, 2, 3);
    chk("emp_both_valid", valid_out, 0);
    chk("emp_both_empty", fifo_empty, 0);
    for (int i = 0; i < 7; i++) cycle(1, 0, 6'(8'h06 + i), 2, 3);
    chk("fill_full", fifo_full, 1);
    cycle(1, 1, 6'h3E, 2, 3);
    chk("full_both_valid", valid_out, 1);
    chk("full_both_dout", data_out, 6'h05);
    chk("full_both_full", fifo_full, 0);
    chk("full_both_err", error_out, 1);
    for (int i = 0; i < 7; i++) cycle(0, 1, 6'h00, 2, 3);
    chk("full_both_drop", data_out, 6'h0C);

    // Asynchronous reset between edges with count 5
    do_reset();
    cycle(0, 1, 6'h00, 2, 3);
    for (int i = 0; i < 5; i++) cycle(1, 0, 6'(8'h31 + i), 2, 3);
    wr_enable = 1'b0;
    rd_enable = 1'b0;
    #3;
    reset = 1'b1;
    #1;
    model_reset();
    reset_checks("async");
    #2;
    reset = 1'b0;
    cycle(1, 0, 6'h2A, 2, 3);
    cycle(0, 1, 6'h00, 2, 3);
    chk("post_rst_dout", data_out, 6'h2A);
    chk("post_rst_valid", valid_out, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
